// File: rtl/prco_lmem_arbiter_pkg.sv
// rtl/prco_lmem_arbiter_pkg.sv - shared constants for the local memory arbiter
package prco_lmem_arbiter_pkg;

    localparam int OWN_W = 2;

    typedef enum logic [OWN_W-1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_D    = 2'd2,
        OWN_H    = 2'd3
    } owner_e;

endpackage

// File: rtl/prco_arb_tagpipe.sv
// rtl/prco_arb_tagpipe.sv - owner-tag shift register tracking in-flight reads
module prco_arb_tagpipe
    import prco_lmem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   flush,
    input  owner_e tag_push,
    output owner_e tag_head
);

    owner_e stage [DEPTH];

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= OWN_NONE;
            end
        end else begin
            stage[0] <= tag_push;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_head = stage[DEPTH-1];

endmodule

// File: rtl/prco_lmem_arbiter.sv
// rtl/prco_lmem_arbiter.sv - single-port local memory arbiter for fetch/data
// Optional host/debug loader port and core hold enabled by PRCO_ARB_HOST_EN.
module prco_lmem_arbiter
    import prco_lmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              q_f_gnt,
    output logic              q_f_rvalid,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_din,
    output logic              q_d_gnt,
    output logic              q_d_rvalid,
`ifdef PRCO_ARB_HOST_EN
    input  logic              i_h_req,
    input  logic              i_h_we,
    input  logic [ADDR_W-1:0] i_h_addr,
    input  logic [DATA_W-1:0] i_h_din,
    output logic              q_h_gnt,
    output logic              q_h_rvalid,
    output logic              q_core_hold,
`endif
    output logic [DATA_W-1:0] q_rdata,
    output logic              q_mem_en,
    output logic              q_mem_we,
    output logic [ADDR_W-1:0] q_mem_addr,
    output logic [DATA_W-1:0] q_mem_din,
    input  logic [DATA_W-1:0] i_mem_dout
);

    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_din;
    logic              h_gnt;
    logic              f_gnt;
    logic              d_gnt;
    logic              any_gnt;
    logic              fetch_due;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    owner_e            sel_tag;
    owner_e            head_tag;
    logic [RUN_W-1:0]  run_cnt;

`ifdef PRCO_ARB_HOST_EN
    assign h_req  = i_h_req;
    assign h_we   = i_h_we;
    assign h_addr = i_h_addr;
    assign h_din  = i_h_din;
`else
    assign h_req  = 1'b0;
    assign h_we   = 1'b0;
    assign h_addr = '0;
    assign h_din  = '0;
`endif

    // fetch only overrides data once data has won MAX_DATA_RUN times in a row
    assign fetch_due = i_f_req && (run_cnt == RUN_MAX);

    always_comb begin
        h_gnt = 1'b0;
        d_gnt = 1'b0;
        f_gnt = 1'b0;
        if (!i_reset) begin
            if (h_req) begin
                h_gnt = 1'b1;
            end else if (i_d_req && !fetch_due) begin
                d_gnt = 1'b1;
            end else if (i_f_req) begin
                f_gnt = 1'b1;
            end
        end
    end

    assign any_gnt = h_gnt || d_gnt || f_gnt;
    assign q_f_gnt = f_gnt;
    assign q_d_gnt = d_gnt;

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = i_f_addr;
        sel_din  = q_mem_din;
        sel_tag  = OWN_NONE;
        if (h_gnt) begin
            sel_we   = h_we;
            sel_addr = h_addr;
            sel_din  = h_din;
            sel_tag  = h_we ? OWN_NONE : OWN_H;
        end else if (d_gnt) begin
            sel_we   = i_d_we;
            sel_addr = i_d_addr;
            sel_din  = i_d_din;
            sel_tag  = i_d_we ? OWN_NONE : OWN_D;
        end else if (f_gnt) begin
            sel_tag  = OWN_F;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            q_mem_en   <= 1'b0;
            q_mem_we   <= 1'b0;
            q_mem_addr <= '0;
            q_mem_din  <= '0;
        end else begin
            q_mem_en <= any_gnt;
            q_mem_we <= any_gnt && sel_we;
            if (any_gnt) begin
                q_mem_addr <= sel_addr;
                q_mem_din  <= sel_din;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_f_req || f_gnt) begin
            run_cnt <= '0;
        end else if (d_gnt) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    prco_arb_tagpipe #(
        .DEPTH(1 + MEM_LAT)
    ) u_tagpipe (
        .clk     (i_clk),
        .flush   (i_reset),
        .tag_push(sel_tag),
        .tag_head(head_tag)
    );

    assign q_rdata    = i_mem_dout;
    assign q_f_rvalid = !i_reset && (head_tag == OWN_F);
    assign q_d_rvalid = !i_reset && (head_tag == OWN_D);

`ifdef PRCO_ARB_HOST_EN
    localparam int PEND_W = $clog2(MEM_LAT + 2) + 1;

    logic [PEND_W-1:0] h_pend;
    logic [PEND_W-1:0] h_pend_nxt;

    assign q_h_gnt    = h_gnt;
    assign q_h_rvalid = !i_reset && (head_tag == OWN_H);

    always_comb begin
        h_pend_nxt = h_pend;
        if (h_gnt && !h_we) begin
            h_pend_nxt = h_pend_nxt + PEND_W'(1);
        end
        if (q_h_rvalid) begin
            h_pend_nxt = h_pend_nxt - PEND_W'(1);
        end
    end

    // hold the core until the host has dropped its request and drained its reads
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            h_pend      <= '0;
            q_core_hold <= 1'b0;
        end else begin
            h_pend      <= h_pend_nxt;
            q_core_hold <= i_h_req || (h_pend_nxt != '0);
        end
    end
`endif

endmodule
